alu_issue_stage: RTL and testbench

ID/EX pipeline register and operand-select stage directly upstream of the ALU (alu_r0, DELAY=0).
- Accepts decoded instructions and selects each operand from one of three sources: the register file, the immediate, or forwarding paths.
- Detects load-use hazards and inserts one bubble when needed.
- Drives the ALU's packed dataIn, ctrl and shamt from registers.

---
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register and operand select ahead of the ALU: forwards from the
// EX result and the MEM/WB write port, and inserts one bubble per load-use hazard.
module alu_issue_stage #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned CTRL_WIDTH     = 6,
   parameter int unsigned SHAMT_WIDTH    = 5,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CTRL_WIDTH-1:0]       in_ctrl,
   input  logic [SHAMT_WIDTH-1:0]      in_shamt,
   input  logic [REG_ADDR_WIDTH-1:0]   in_a_addr,
   input  logic [REG_ADDR_WIDTH-1:0]   in_b_addr,
   input  logic                        in_a_used,
   input  logic                        in_b_used,
   input  logic [DATA_WIDTH-1:0]       in_a_data,
   input  logic [DATA_WIDTH-1:0]       in_b_data,
   input  logic                        in_use_imm,
   input  logic [DATA_WIDTH-1:0]       in_imm,
   input  logic [REG_ADDR_WIDTH-1:0]   in_rd_addr,
   input  logic                        in_wr_en,
   input  logic                        in_is_load,
   input  logic                        flush,
   input  logic                        ex_stall,
   input  logic [DATA_WIDTH-1:0]       alu_result,
   input  logic                        mem_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0]   mem_wr_addr,
   input  logic [DATA_WIDTH-1:0]       mem_wr_data,
   output logic [2*DATA_WIDTH-1:0]     alu_data_in,
   output logic [CTRL_WIDTH-1:0]       alu_ctrl,
   output logic [SHAMT_WIDTH-1:0]      alu_shamt,
   output logic                        out_valid,
   output logic [REG_ADDR_WIDTH-1:0]   out_rd_addr,
   output logic                        out_wr_en,
   output logic                        out_is_load
);

   logic [DATA_WIDTH-1:0]     op_a_d, op_a_q, op_b_d, op_b_q, sel_a, sel_b;
   logic [CTRL_WIDTH-1:0]     ctrl_d, ctrl_q;
   logic [SHAMT_WIDTH-1:0]    shamt_d, shamt_q;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_d, rd_addr_q;
   logic                      valid_d, valid_q, wr_en_d, wr_en_q, is_load_d, is_load_q;
   logic                      ex_fwd_ok, hazard, a_hit, b_hit;

   // A load in EX has no result yet, so it is never a forwarding source.
   assign ex_fwd_ok = valid_q && wr_en_q && !is_load_q;

   function automatic logic [DATA_WIDTH-1:0] fwd_sel(
      input logic                      used,
      input logic [REG_ADDR_WIDTH-1:0] addr,
      input logic [DATA_WIDTH-1:0]     rf_data,
      input logic                      ex_ok,
      input logic [REG_ADDR_WIDTH-1:0] ex_addr,
      input logic [DATA_WIDTH-1:0]     ex_data,
      input logic                      wb_en,
      input logic [REG_ADDR_WIDTH-1:0] wb_addr,
      input logic [DATA_WIDTH-1:0]     wb_data
   );
      logic [DATA_WIDTH-1:0] res;
      res = rf_data;
      if (used && addr != '0) begin
         if (ex_ok && ex_addr == addr) begin
            res = ex_data;
         end else if (wb_en && wb_addr == addr) begin
            res = wb_data;
         end
      end
      return res;
   endfunction

   always_comb begin
      sel_a = fwd_sel(in_a_used, in_a_addr, in_a_data, ex_fwd_ok, rd_addr_q, alu_result,
                      mem_wr_en, mem_wr_addr, mem_wr_data);
      sel_b = fwd_sel(in_b_used, in_b_addr, in_b_data, ex_fwd_ok, rd_addr_q, alu_result,
                      mem_wr_en, mem_wr_addr, mem_wr_data);
      if (in_use_imm) begin
         sel_b = in_imm;
      end
   end

   assign a_hit  = in_a_used && in_a_addr == rd_addr_q;
   assign b_hit  = in_b_used && !in_use_imm && in_b_addr == rd_addr_q;
   assign hazard = in_valid && valid_q && is_load_q && wr_en_q && rd_addr_q != '0 &&
                   (a_hit || b_hit);

   assign in_ready = !rst && (flush || (!ex_stall && !hazard));

   always_comb begin
      valid_d   = valid_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      ctrl_d    = ctrl_q;
      shamt_d   = shamt_q;
      rd_addr_d = rd_addr_q;
      wr_en_d   = wr_en_q;
      is_load_d = is_load_q;
      if (flush || (!ex_stall && (hazard || !in_valid))) begin
         valid_d   = 1'b0;
         op_a_d    = '0;
         op_b_d    = '0;
         ctrl_d    = '0;
         shamt_d   = '0;
         rd_addr_d = '0;
         wr_en_d   = 1'b0;
         is_load_d = 1'b0;
      end else if (!ex_stall) begin
         valid_d   = 1'b1;
         op_a_d    = sel_a;
         op_b_d    = sel_b;
         ctrl_d    = in_ctrl;
         shamt_d   = in_shamt;
         rd_addr_d = in_rd_addr;
         wr_en_d   = in_wr_en;
         is_load_d = in_is_load;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         ctrl_q    <= '0;
         shamt_q   <= '0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         is_load_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         ctrl_q    <= ctrl_d;
         shamt_q   <= shamt_d;
         rd_addr_q <= rd_addr_d;
         wr_en_q   <= wr_en_d;
         is_load_q <= is_load_d;
      end
   end

   assign alu_data_in = {op_b_q, op_a_q};
   assign alu_ctrl    = ctrl_q;
   assign alu_shamt   = shamt_q;
   assign out_valid   = valid_q;
   assign out_rd_addr = rd_addr_q;
   assign out_wr_en   = wr_en_q;
   assign out_is_load = is_load_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a directed cycle table for the hazard/forwarding corners,
// then random traffic checked against a rule-level model of the output register.
module tb_alu_issue_stage;

   typedef struct {
      logic        rst, valid, a_used, b_used, use_imm, wr_en, is_load, flush, stall, mem_wr_en;
      logic [5:0]  ctrl;
      logic [4:0]  shamt, a_addr, b_addr, rd, mem_addr;
      logic [31:0] a_data, b_data, imm, alu_res, mem_data;
   } in_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] a, b;
      logic [5:0]  ctrl;
      logic [4:0]  shamt, rd;
      logic        wr, ld;
   } out_t;

   typedef struct {
      in_t   i;
      logic  rdy;
      out_t  o;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_a_used, in_b_used, in_use_imm, in_wr_en, in_is_load;
   logic        flush, ex_stall, mem_wr_en, out_valid, out_wr_en, out_is_load;
   logic [5:0]  in_ctrl, alu_ctrl;
   logic [4:0]  in_shamt, in_a_addr, in_b_addr, in_rd_addr, mem_wr_addr, alu_shamt, out_rd_addr;
   logic [31:0] in_a_data, in_b_data, in_imm, alu_result, mem_wr_data;
   logic [63:0] alu_data_in;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];
   out_t model;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
      .in_shamt(in_shamt), .in_a_addr(in_a_addr), .in_b_addr(in_b_addr),
      .in_a_used(in_a_used), .in_b_used(in_b_used), .in_a_data(in_a_data),
      .in_b_data(in_b_data), .in_use_imm(in_use_imm), .in_imm(in_imm),
      .in_rd_addr(in_rd_addr), .in_wr_en(in_wr_en), .in_is_load(in_is_load), .flush(flush),
      .ex_stall(ex_stall), .alu_result(alu_result), .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .alu_data_in(alu_data_in),
      .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt), .out_valid(out_valid),
      .out_rd_addr(out_rd_addr), .out_wr_en(out_wr_en), .out_is_load(out_is_load)
   );

   function automatic in_t idle();
      in_t v;
      v = '{default: '0};
      return v;
   endfunction

   function automatic out_t mk(logic val, logic [31:0] a, logic [31:0] b, logic [5:0] c,
                               logic [4:0] s, logic [4:0] rd, logic wr, logic ld);
      out_t o;
      o = '{valid: val, a: a, b: b, ctrl: c, shamt: s, rd: rd, wr: wr, ld: ld};
      return o;
   endfunction

   function automatic string fmt(out_t o);
      return $sformatf("v=%0b a=%h b=%h ctrl=%h sh=%0d rd=%0d wr=%0b ld=%0b",
                       o.valid, o.a, o.b, o.ctrl, o.shamt, o.rd, o.wr, o.ld);
   endfunction

   task automatic add(in_t v, logic rdy, out_t o);
      vec_t e;
      e.i = v; e.rdy = rdy; e.o = o;
      vecs.push_back(e);
   endtask

   // Reference: operand value from the forwarding rules, given the current EX contents.
   function automatic logic [31:0] m_operand(out_t cur, logic used, logic [4:0] addr,
                                             logic [31:0] rf, in_t i);
      if (!used || addr == 0) return rf;
      if (cur.valid && cur.wr && !cur.ld && cur.rd == addr) return i.alu_res;
      if (i.mem_wr_en && i.mem_addr == addr) return i.mem_data;
      return rf;
   endfunction

   task automatic m_step(in_t i, output logic rdy, output out_t nxt);
      logic hz;
      hz = i.valid && model.valid && model.ld && model.wr && model.rd != 0 &&
           ((i.a_used && i.a_addr == model.rd) ||
            (i.b_used && !i.use_imm && i.b_addr == model.rd));
      rdy = !i.rst && (i.flush || (!i.stall && !hz));
      if (i.rst || i.flush) nxt = '0;
      else if (i.stall) nxt = model;
      else if (hz || !i.valid) nxt = '0;
      else nxt = mk(1'b1, m_operand(model, i.a_used, i.a_addr, i.a_data, i),
                    i.use_imm ? i.imm : m_operand(model, i.b_used, i.b_addr, i.b_data, i),
                    i.ctrl, i.shamt, i.rd, i.wr_en, i.is_load);
   endtask

   task automatic drive(in_t v);
      rst = v.rst; in_valid = v.valid; in_ctrl = v.ctrl; in_shamt = v.shamt;
      in_a_addr = v.a_addr; in_b_addr = v.b_addr; in_a_used = v.a_used; in_b_used = v.b_used;
      in_a_data = v.a_data; in_b_data = v.b_data; in_use_imm = v.use_imm; in_imm = v.imm;
      in_rd_addr = v.rd; in_wr_en = v.wr_en; in_is_load = v.is_load; flush = v.flush;
      ex_stall = v.stall; alu_result = v.alu_res; mem_wr_en = v.mem_wr_en;
      mem_wr_addr = v.mem_addr; mem_wr_data = v.mem_data;
   endtask

   task automatic run_cycle(in_t v, logic rdy, out_t exp_o, string name);
      out_t got;
      drive(v);
      #2;
      checks++;
      if (in_ready !== rdy) begin
         errors++;
         $display("FAIL %s in_ready: got %b want %b", name, in_ready, rdy);
      end
      @(posedge clk);
      #1;
      got = mk(out_valid, alu_data_in[31:0], alu_data_in[63:32], alu_ctrl, alu_shamt,
               out_rd_addr, out_wr_en, out_is_load);
      checks++;
      if (got !== exp_o) begin
         errors++;
         $display("FAIL %s outputs: got %s want %s", name, fmt(got), fmt(exp_o));
      end
   endtask

   initial begin
      in_t  v;
      logic rdy;
      out_t nxt;

      // 0: reset with garbage on the input
      v = idle(); v.rst = 1; v.valid = 1; v.ctrl = 6'h3f; v.a_data = 32'h1;
      add(v, 0, '0);
      // 1: add r3 <- 5 + 7
      v = idle(); v.valid = 1; v.ctrl = 6'h20; v.a_addr = 1; v.a_used = 1; v.a_data = 5;
      v.b_addr = 2; v.b_used = 1; v.b_data = 7; v.rd = 3; v.wr_en = 1;
      add(v, 1, mk(1, 32'd5, 32'd7, 6'h20, 0, 3, 1, 0));
      // 2: reads r3; EX forward beats the simultaneous MEM/WB write
      v = idle(); v.valid = 1; v.ctrl = 6'h22; v.a_addr = 3; v.a_used = 1; v.a_data = 1;
      v.b_used = 1; v.b_data = 32'h22; v.rd = 5; v.wr_en = 1; v.alu_res = 32'h1234;
      v.mem_wr_en = 1; v.mem_addr = 3; v.mem_data = 32'h9999;
      add(v, 1, mk(1, 32'h1234, 32'h22, 6'h22, 0, 5, 1, 0));
      // 3: load r4, base forwarded from r5 in EX
      v = idle(); v.valid = 1; v.ctrl = 6'h21; v.a_addr = 5; v.a_used = 1; v.alu_res = 32'h100;
      v.use_imm = 1; v.imm = 8; v.b_data = 32'h77; v.rd = 4; v.wr_en = 1; v.is_load = 1;
      add(v, 1, mk(1, 32'h100, 32'h8, 6'h21, 0, 4, 1, 1));
      // 4: user of r4 -> stall one cycle, bubble out
      v = idle(); v.valid = 1; v.ctrl = 6'h20; v.a_addr = 4; v.a_used = 1; v.a_data = 32'hdead;
      v.b_data = 3; v.rd = 6; v.wr_en = 1; v.alu_res = 32'h7777;
      add(v, 0, '0);
      // 5: load data arrives through MEM/WB
      v.mem_wr_en = 1; v.mem_addr = 4; v.mem_data = 32'hcafe;
      add(v, 1, mk(1, 32'hcafe, 32'h3, 6'h20, 0, 6, 1, 0));
      // 6: write r0
      v = idle(); v.valid = 1; v.ctrl = 6'h20; v.a_addr = 1; v.a_data = 32'h11;
      v.b_data = 32'h22; v.rd = 0; v.wr_en = 1;
      add(v, 1, mk(1, 32'h11, 32'h22, 6'h20, 0, 0, 1, 0));
      // 7: read r0: never forwarded
      v = idle(); v.valid = 1; v.ctrl = 6'h24; v.a_used = 1; v.alu_res = 32'hffff;
      v.mem_wr_en = 1; v.mem_data = 32'haaaa; v.rd = 7; v.wr_en = 1;
      add(v, 1, mk(1, 32'h0, 32'h0, 6'h24, 0, 7, 1, 0));
      // 8-10: three stall cycles hold everything
      v = idle(); v.valid = 1; v.ctrl = 6'h25; v.a_data = 32'h55; v.rd = 8; v.wr_en = 1;
      v.stall = 1;
      for (int k = 0; k < 3; k++) add(v, 0, mk(1, 32'h0, 32'h0, 6'h24, 0, 7, 1, 0));
      // 11: flush during stall
      v.flush = 1;
      add(v, 1, '0);
      // 12: load r9
      v = idle(); v.valid = 1; v.ctrl = 6'h23; v.a_data = 32'h40; v.use_imm = 1; v.imm = 4;
      v.rd = 9; v.wr_en = 1; v.is_load = 1;
      add(v, 1, mk(1, 32'h40, 32'h4, 6'h23, 0, 9, 1, 1));
      // 13: immediate B with b_addr matching the load: no hazard
      v = idle(); v.valid = 1; v.ctrl = 6'h20; v.a_data = 1; v.b_addr = 9; v.b_used = 1;
      v.b_data = 32'h5; v.use_imm = 1; v.imm = 32'hfffffff0; v.rd = 10; v.wr_en = 1;
      add(v, 1, mk(1, 32'h1, 32'hfffffff0, 6'h20, 0, 10, 1, 0));
      // 14: no instruction
      add(idle(), 1, '0);
      // 15: shift with B forwarded from MEM/WB
      v = idle(); v.valid = 1; v.shamt = 5; v.a_data = 3; v.b_addr = 12; v.b_used = 1;
      v.b_data = 9; v.mem_wr_en = 1; v.mem_addr = 12; v.mem_data = 32'h4242; v.rd = 11;
      v.wr_en = 1;
      add(v, 1, mk(1, 32'h3, 32'h4242, 6'h00, 5, 11, 1, 0));
      // 16: reset mid-stream
      v.rst = 1;
      add(v, 0, '0);

      for (int n = 0; n < vecs.size(); n++)
         run_cycle(vecs[n].i, vecs[n].rdy, vecs[n].o, $sformatf("vec%0d", n));

      model = '0;
      for (int n = 0; n < 500; n++) begin
         v.rst = ($urandom_range(0, 49) == 0);
         v.valid = ($urandom_range(0, 3) != 0);
         v.flush = ($urandom_range(0, 9) == 0);
         v.stall = ($urandom_range(0, 5) == 0);
         v.ctrl = 6'($urandom); v.shamt = 5'($urandom);
         v.a_addr = 5'($urandom_range(0, 3)); v.b_addr = 5'($urandom_range(0, 3));
         v.a_used = 1'($urandom); v.b_used = 1'($urandom); v.use_imm = 1'($urandom);
         v.a_data = $urandom; v.b_data = $urandom; v.imm = $urandom;
         v.rd = 5'($urandom_range(0, 3)); v.wr_en = ($urandom_range(0, 3) != 0);
         v.is_load = ($urandom_range(0, 2) == 0);
         v.alu_res = $urandom; v.mem_wr_en = 1'($urandom);
         v.mem_addr = 5'($urandom_range(0, 3)); v.mem_data = $urandom;
         m_step(v, rdy, nxt);
         run_cycle(v, rdy, nxt, $sformatf("rand%0d", n));
         model = nxt;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
